// File: rtl/nibble_seq_detector_pkg.sv
// Shared definitions for the nibble sequence detector: FSM state encodings
// used by the RTL and the testbench alike.
package nibble_seq_detector_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } state_t;

endpackage

// File: rtl/nibble_seq_detector_sat_counter.sv
// Saturating up-counter with synchronous reset and a clear that overrides increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/nibble_seq_detector.sv
// Detects the nibble pattern P0,P1,P2 in a valid-qualified stream, overlapping
// matches included, with a registered detect pulse and a saturating match count.
module nibble_seq_detector
  import nibble_seq_detector_pkg::*;
#(
  parameter logic [3:0]  P0    = 4'h3,
  parameter logic [3:0]  P1    = 4'h7,
  parameter logic [3:0]  P2    = 4'hB,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             din_valid,
  input  logic [3:0]       din,
  input  logic             clr,
  output logic             detect,
  output logic [CNT_W-1:0] match_count,
  output logic [1:0]       state_dbg
);

  // Pattern self-overlap is fixed by the parameters, so fold it into constants.
  localparam bit ALL_EQ   = (P0 == P1) && (P1 == P2);
  localparam bit P2_EQ_P0 = (P2 == P0);
  localparam bit P0_EQ_P1 = (P0 == P1);
  localparam state_t AFTER_MATCH = ALL_EQ ? S2 : (P2_EQ_P0 ? S1 : S0);

  state_t state;
  state_t state_nx;
  logic   match;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S0;
      detect <= 1'b0;
    end else begin
      state  <= state_nx;
      detect <= match;
    end
  end

  always_comb begin
    state_nx = state;
    if (din_valid) begin
      unique case (state)
        S0: state_nx = (din == P0) ? S1 : S0;
        S1: begin
          if (din == P1)      state_nx = S2;
          else if (din == P0) state_nx = S1;
          else                state_nx = S0;
        end
        S2: begin
          if (din == P2)                 state_nx = AFTER_MATCH;
          else if (P0_EQ_P1 && din == P1) state_nx = S2;
          else if (din == P0)            state_nx = S1;
          else                           state_nx = S0;
        end
        default: state_nx = S0;
      endcase
    end
  end

  always_comb begin
    match = din_valid && (state == S2) && (din == P2);
  end

  assign state_dbg = state;

  sat_counter #(.W(CNT_W)) u_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (clr),
    .inc (match),
    .q   (match_count)
  );

endmodule

// File: tb/tb_nibble_seq_detector.sv
// Scoreboard bench: three detector configurations share one stimulus stream and
// are compared each cycle against a history-based pattern model.
module tb_nibble_seq_detector;
  import nibble_seq_detector_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       din_valid = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] din = '0;

  logic       det_a, det_s, det_e;
  logic [7:0] mc_a, mc_e;
  logic [1:0] mc_s;
  logic [1:0] sd_a, sd_s, sd_e;

  always #5 CLK = ~CLK;

  nibble_seq_detector dut_a (
    .CLK(CLK), .RST(RST), .din_valid(din_valid), .din(din), .clr(clr),
    .detect(det_a), .match_count(mc_a), .state_dbg(sd_a)
  );

  nibble_seq_detector #(.CNT_W(2)) dut_s (
    .CLK(CLK), .RST(RST), .din_valid(din_valid), .din(din), .clr(clr),
    .detect(det_s), .match_count(mc_s), .state_dbg(sd_s)
  );

  nibble_seq_detector #(.P0(4'h5), .P1(4'h5), .P2(4'h5), .CNT_W(8)) dut_e (
    .CLK(CLK), .RST(RST), .din_valid(din_valid), .din(din), .clr(clr),
    .detect(det_e), .match_count(mc_e), .state_dbg(sd_e)
  );

  typedef struct packed {
    logic [2:0]      det;
    logic [2:0][7:0] cnt;
    logic [2:0][1:0] st;
  } exp_t;

  exp_t sbq[$];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  logic [3:0] pat [3][3] = '{'{4'h3, 4'h7, 4'hB}, '{4'h3, 4'h7, 4'hB}, '{4'h5, 4'h5, 4'h5}};
  int cmax [3] = '{255, 3, 255};

  // Model: the last three valid nibbles since reset, plus per-config counts.
  int         hlen = 0;
  logic [3:0] h0 = '0, h1 = '0, h2 = '0;
  int         mcnt [3] = '{0, 0, 0};

  function automatic state_t mstate(input int i);
    if (hlen >= 2 && h1 == pat[i][0] && h0 == pat[i][1]) return S2;
    if (hlen >= 1 && h0 == pat[i][0]) return S1;
    return S0;
  endfunction

  task automatic step(input logic r, input logic v, input logic [3:0] d, input logic c);
    exp_t e;
    logic m;
    RST = r; din_valid = v; din = d; clr = c;
    e = '0;
    if (r) begin
      hlen = 0;
      for (int i = 0; i < 3; i++) mcnt[i] = 0;
    end else if (v) begin
      h2 = h1; h1 = h0; h0 = d;
      if (hlen < 3) hlen++;
    end
    for (int i = 0; i < 3; i++) begin
      m = !r && v && hlen >= 3 && h2 == pat[i][0] && h1 == pat[i][1] && h0 == pat[i][2];
      if (!r) begin
        if (c) mcnt[i] = 0;
        else if (m && mcnt[i] < cmax[i]) mcnt[i]++;
      end
      e.det[i] = m;
      e.cnt[i] = 8'(mcnt[i]);
      e.st[i]  = mstate(i);
    end
    sbq.push_back(e);
    @(posedge CLK);
    #2;
  endtask

  task automatic feed(input logic [3:0] d);
    step(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, $urandom_range(0, 15), 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("detect_a", int'(det_a), int'(e.det[0]));
        chk("detect_s", int'(det_s), int'(e.det[1]));
        chk("detect_e", int'(det_e), int'(e.det[2]));
        chk("count_a",  int'(mc_a),  int'(e.cnt[0]));
        chk("count_s",  int'(mc_s),  int'(e.cnt[1]));
        chk("count_e",  int'(mc_e),  int'(e.cnt[2]));
        chk("state_a",  int'(sd_a),  int'(e.st[0]));
        chk("state_s",  int'(sd_s),  int'(e.st[1]));
        chk("state_e",  int'(sd_e),  int'(e.st[2]));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    step(1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 4'h3, 1'b1);

    feed(4'h3); feed(4'h7); feed(4'hB); idle(2);
    feed(4'h3); feed(4'h3); feed(4'h7); feed(4'hB); idle(1);
    feed(4'h3); idle(5); feed(4'h7); feed(4'hB); idle(1);
    for (int k = 0; k < 5; k++) feed(4'h5);
    idle(1);

    step(1'b1, 1'b0, 4'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      feed(4'h3); feed(4'h7); feed(4'hB);
    end
    feed(4'h3); feed(4'h7); step(1'b0, 1'b1, 4'hB, 1'b1); idle(2);

    feed(4'h3); feed(4'h7); step(1'b1, 1'b1, 4'hB, 1'b0); feed(4'hB); idle(1);

    for (int k = 0; k < 2000; k++) begin
      logic       r, v, c;
      logic [3:0] d;
      int unsigned sel;
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, 7);
      case (sel)
        0: d = 4'h3;
        1: d = 4'h7;
        2: d = 4'hB;
        3, 4: d = 4'h5;
        default: d = 4'($urandom_range(0, 15));
      endcase
      step(r, v, d, c);
    end

    repeat (3) @(posedge CLK);
    #1;
    chk("scoreboard_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
